apb_slave_regs: RTL

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

---
 rtl/apb_slave_regs.sv | 123 ++++++++++++
 1 files changed

// File: rtl/apb_slave_regs.sv
// APB register slave: REG_NUM-1 RW words plus a read-only transfer counter.
// Define APB_WSTRB_EN to add the pstrb port and byte-lane write masking.
module apb_slave_regs #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int REG_NUM     = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int IW   = ADDR_WIDTH - 2;
  localparam int LAST = REG_NUM - 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [REG_NUM-2:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

  logic [IW-1:0]         idx;
  logic                  err;
  logic                  wr_en;
  logic [NB-1:0]         strb;
  logic [DATA_WIDTH-1:0] rsel;

  assign idx = paddr[ADDR_WIDTH-1:2];

`ifdef APB_WSTRB_EN
  assign strb = pstrb;
`else
  assign strb = '1;
`endif

  // The counter word is readable but never writable.
  assign err = (paddr[1:0] != 2'b00)
            || (32'(idx) >= REG_NUM)
            || (pwrite && (32'(idx) == LAST));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          wait_d  = 4'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
        if (!(psel && penable)) begin
          state_d = IDLE;
        end else if (wait_q == 4'd0) begin
          pready  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pslverr = pready & err;
  assign wr_en   = pready & pwrite & ~err;

  always_comb begin
    rsel = '0;
    if (32'(idx) == LAST) rsel = cnt_q;
    for (int i = 0; i < LAST; i++) begin
      if (32'(idx) == i) rsel = regs_q[i];
    end
  end

  assign prdata = (pready && !pwrite && !err) ? rsel : '0;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      for (int i = 0; i < LAST; i++) begin
        for (int b = 0; b < NB; b++) begin
          if ((32'(idx) == i) && strb[b])
            regs_d[i][8*b +: 8] = pwdata[8*b +: 8];
        end
      end
    end
  end

  // Error transfers still count; the read path sees the old value.
  assign cnt_d = pready ? cnt_q + DATA_WIDTH'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      regs_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      regs_q  <= regs_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
